// File: rtl/wb_queue.sv
// Writeback queue between multicycle producers and the integer register file write port.
// Drains one entry per cycle when the port is free and forwards the newest queued value to the read stage.
module wb_queue #(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [4:0]               in_rd,
  input  logic [XLEN-1:0]          in_data,
  input  logic                     wb_en,
  output logic                     wr,
  output logic [4:0]               rd,
  output logic [XLEN-1:0]          rd_data,
  input  logic [4:0]               rs1,
  input  logic [4:0]               rs2,
  output logic                     rs1_pending,
  output logic [XLEN-1:0]          rs1_fwd,
  output logic                     rs2_pending,
  output logic [XLEN-1:0]          rs2_fwd,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  // Handshake: a push completes at a rising edge where in_valid && in_ready;
  // in_ready depends only on registered occupancy, and a pop completes where wr is high.
  logic [4:0]      ent_rd   [DEPTH];
  logic [XLEN-1:0] ent_data [DEPTH];
  logic [AW-1:0]   head;
  logic [AW-1:0]   tail;
  logic            push;
  logic            enq;
  logic            pop;

  assign in_ready = (count < FULL);
  assign empty    = (count == '0);
  assign push     = in_valid && in_ready;
  // Writes to x0 complete the handshake but never occupy an entry.
  assign enq      = push && (in_rd != 5'd0);
  assign wr       = wb_en && !empty;
  assign pop      = wr;

  always_comb begin
    rd      = '0;
    rd_data = '0;
    if (wr) begin
      rd      = ent_rd[head];
      rd_data = ent_data[head];
    end
  end

  // Walk from oldest to newest so the last match (closest to tail) wins.
  function automatic logic [XLEN:0] lookup(input logic [4:0] rs);
    logic [XLEN:0] r;
    logic [AW-1:0] idx;
    r = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = head + AW'(i);
      if ((CW'(i) < count) && (rs != 5'd0) && (ent_rd[idx] == rs))
        r = {1'b1, ent_data[idx]};
    end
    return r;
  endfunction

  always_comb begin
    {rs1_pending, rs1_fwd} = lookup(rs1);
    {rs2_pending, rs2_fwd} = lookup(rs2);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
    end else begin
      if (enq) tail <= tail + AW'(1);
      if (pop) head <= head + AW'(1);
      case ({enq, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage is not reset; occupancy alone decides which entries are live.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_rd[tail]   <= in_rd;
      ent_data[tail] <= in_data;
    end
  end

endmodule

// File: tb/tb_wb_queue.sv
// Self-checking bench for wb_queue: directed scenarios plus random traffic,
// checked by a queue-based reference model and a negedge monitor.
module tb_wb_queue;

  localparam int DEPTH = 4;
  localparam int XLEN  = 32;
  localparam int W     = 5 + XLEN;

  logic             clk = 1'b0;
  logic             rst;
  logic             in_valid;
  logic             in_ready;
  logic [4:0]       in_rd;
  logic [XLEN-1:0]  in_data;
  logic             wb_en;
  logic             wr;
  logic [4:0]       rd;
  logic [XLEN-1:0]  rd_data;
  logic [4:0]       rs1;
  logic [4:0]       rs2;
  logic             rs1_pending;
  logic [XLEN-1:0]  rs1_fwd;
  logic             rs2_pending;
  logic [XLEN-1:0]  rs2_fwd;
  logic             empty;
  logic [$clog2(DEPTH):0] count;

  int checks = 0;
  int errors = 0;

  // Undrained writebacks in program order, {rd, data}; front is the next to drain.
  logic [W-1:0] exp_q[$];
  logic         m_ready = 1'b1;

  wb_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_rd(in_rd), .in_data(in_data),
    .wb_en(wb_en), .wr(wr), .rd(rd), .rd_data(rd_data),
    .rs1(rs1), .rs2(rs2),
    .rs1_pending(rs1_pending), .rs1_fwd(rs1_fwd),
    .rs2_pending(rs2_pending), .rs2_fwd(rs2_fwd),
    .empty(empty), .count(count)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: act=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: act=0x%0h exp=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference forwarding: newest matching queued entry, never for x0.
  task automatic model_fwd(input logic [4:0] rs, output logic p, output logic [XLEN-1:0] d);
    logic [W-1:0] e;
    p = 1'b0;
    d = '0;
    if (rs != 5'd0)
      for (int i = 0; i < exp_q.size(); i++) begin
        e = exp_q[i];
        if (e[W-1:XLEN] == rs) begin
          p = 1'b1;
          d = e[XLEN-1:0];
        end
      end
  endtask

  // Model update at the clock edge: accept a push when the model had room.
  always @(posedge clk or posedge rst) begin
    if (rst) exp_q.delete();
    else if (in_valid && m_ready && in_rd != 5'd0) exp_q.push_back({in_rd, in_data});
  end

  // Monitor: compare every output each cycle, pop the model on a drain.
  always @(negedge clk) begin
    int n;
    logic p;
    logic [XLEN-1:0] d;
    logic exp_wr;
    logic [W-1:0] e;
    n = exp_q.size();
    m_ready = (n < DEPTH);
    chk("count", 64'(count), 64'(n));
    chk("empty", 64'(empty), 64'(n == 0));
    chk("in_ready", 64'(in_ready), 64'(m_ready));
    model_fwd(rs1, p, d);
    chk("rs1_pending", 64'(rs1_pending), 64'(p));
    chk("rs1_fwd", 64'(rs1_fwd), 64'(d));
    model_fwd(rs2, p, d);
    chk("rs2_pending", 64'(rs2_pending), 64'(p));
    chk("rs2_fwd", 64'(rs2_fwd), 64'(d));
    exp_wr = wb_en && (n > 0) && !rst;
    chk("wr", 64'(wr), 64'(exp_wr));
    if (exp_wr) begin
      e = exp_q.pop_front();
      chk("rd", 64'(rd), 64'(e[W-1:XLEN]));
      chk("rd_data", 64'(rd_data), 64'(e[XLEN-1:0]));
    end else begin
      chk("rd_idle", 64'(rd), 64'd0);
      chk("rd_data_idle", 64'(rd_data), 64'd0);
    end
  end

  // driver tasks
  task automatic drive(input logic v, input logic [4:0] r, input logic [XLEN-1:0] d, input logic w);
    in_valid = v;
    in_rd    = r;
    in_data  = d;
    wb_en    = w;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1;
    rs1 = '0;
    rs2 = '0;
    drive(1'b0, 5'd0, '0, 1'b0);
    #3;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_empty", 64'(empty), 64'd1);
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_wr", 64'(wr), 64'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    // Fill while stalled, refuse a fifth push, then drain in order.
    for (int i = 1; i <= 4; i++) begin
      drive(1'b1, 5'(i), XLEN'(i * 'h11), 1'b0);
      tick();
    end
    drive(1'b1, 5'd5, 32'h55, 1'b0);
    #2;
    chk("full_count", 64'(count), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b1);
    for (int i = 0; i < 4; i++) tick();
    #2;
    chk("drained_empty", 64'(empty), 64'd1);
    chk("drained_in_ready", 64'(in_ready), 64'd1);

    // x0 writes are accepted and dropped.
    drive(1'b1, 5'd0, 32'hDEAD, 1'b1);
    tick();
    drive(1'b0, 5'd0, '0, 1'b1);
    #2;
    chk("x0_count", 64'(count), 64'd0);
    tick();

    // Newest-wins forwarding for a register queued twice.
    drive(1'b1, 5'd5, 32'hA, 1'b0);
    tick();
    drive(1'b1, 5'd5, 32'hB, 1'b0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b0);
    rs1 = 5'd5;
    rs2 = 5'd6;
    #2;
    chk("fwd_pending", 64'(rs1_pending), 64'd1);
    chk("fwd_newest", 64'(rs1_fwd), 64'hB);
    chk("fwd_nomatch", 64'(rs2_pending), 64'd0);
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    #2;
    chk("fwd_after_pop", 64'(rs1_fwd), 64'hB);
    wb_en = 1'b1;
    tick();
    wb_en = 1'b0;
    #2;
    chk("fwd_all_popped", 64'(rs1_pending), 64'd0);

    // Push and pop every cycle across the pointer wrap.
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'(i + 1), XLEN'(i), 1'b1);
      tick();
      chk("stream_count", 64'(count), 64'd1);
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    tick();
    chk("stream_end_count", 64'(count), 64'd0);

    // A popping entry stays visible to forwarding during its strobe cycle.
    drive(1'b1, 5'd7, 32'h77, 1'b0);
    tick();
    drive(1'b0, 5'd0, '0, 1'b1);
    rs2 = 5'd7;
    #2;
    chk("pop_cycle_pending", 64'(rs2_pending), 64'd1);
    tick();
    #2;
    chk("post_pop_pending", 64'(rs2_pending), 64'd0);

    // Reset in the middle of a drain discards everything at once.
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 5'(9 + i), XLEN'(100 + i), 1'b0);
      tick();
    end
    drive(1'b0, 5'd0, '0, 1'b1);
    tick();
    rst = 1'b1;
    #1;
    chk("midreset_count", 64'(count), 64'd0);
    chk("midreset_empty", 64'(empty), 64'd1);
    chk("midreset_wr", 64'(wr), 64'd0);
    tick();
    rst = 1'b0;
    for (int i = 0; i < 4; i++) tick();

    // Random traffic with a small register range to force collisions.
    for (int c = 0; c < 800; c++) begin
      drive(1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom(),
            1'($urandom_range(0, 2) != 0));
      if (c % 50 < 25) wb_en = ($urandom_range(0, 3) == 0);
      rs1 = 5'($urandom_range(0, 7));
      rs2 = 5'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) rst = 1'b1;
      tick();
      rst = 1'b0;
    end

    drive(1'b0, 5'd0, '0, 1'b1);
    for (int i = 0; i < DEPTH + 2; i++) tick();
    chk("final_empty", 64'(empty), 64'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
